// File: rtl/alu_op_sched.sv
// Scheduler for one ALU operation per command. It gates the ALU clock, starts the ALU and
// waits a bounded time for its result, then writes the result bytes to the TX FIFO.
module alu_op_sched #(
  parameter int FUN_W   = 4,
  parameter int OUT_W   = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  input  logic [FUN_W-1:0]  CMD_FUN,
  input  logic              CMD_ONE_BYTE,
  output logic              CMD_READY,
  output logic              GATE_EN,
  output logic              ALU_EN,
  output logic [FUN_W-1:0]  ALU_FUN,
  input  logic [OUT_W-1:0]  ALU_OUT,
  input  logic              ALU_OUT_VALID,
  input  logic              F_FULL,
  output logic              W_INC,
  output logic [DATA_W-1:0] Wr_DATA,
  output logic              BUSY,
  output logic              ERR
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GATE_ON = 3'd1,
    EXEC    = 3'd2,
    WAIT    = 3'd3,
    WR_LO   = 3'd4,
    WR_HI   = 3'd5
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [FUN_W-1:0]   fun_q, fun_d;
  logic               mode_q, mode_d;
  logic [OUT_W-1:0]   res_q, res_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  hold_q, hold_d;

  logic               gate_en;
  logic               alu_en;
  logic               w_inc;
  logic [DATA_W-1:0]  wr_data;

  function automatic logic [DATA_W-1:0] lo_byte(input logic [OUT_W-1:0] r);
    return r[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] hi_byte(input logic [OUT_W-1:0] r);
    return r[OUT_W-1:DATA_W];
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      fun_q   <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      fun_q   <= fun_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fun_d   = fun_q;
    mode_d  = mode_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    hold_d  = hold_q;
    gate_en = 1'b0;
    alu_en  = 1'b0;
    w_inc   = 1'b0;
    wr_data = hold_q;

    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          fun_d   = CMD_FUN;
          mode_d  = CMD_ONE_BYTE;
          state_d = GATE_ON;
        end
      end
      GATE_ON: begin
        gate_en = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        gate_en = 1'b1;
        alu_en  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        gate_en = 1'b1;
        // A result arriving on the last allowed cycle still counts as success.
        if (ALU_OUT_VALID) begin
          res_d   = ALU_OUT;
          state_d = WR_LO;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_LO: begin
        wr_data = lo_byte(res_q);
        hold_d  = wr_data;
        w_inc   = !F_FULL;
        if (!F_FULL) state_d = mode_q ? IDLE : WR_HI;
      end
      WR_HI: begin
        wr_data = hi_byte(res_q);
        hold_d  = wr_data;
        w_inc   = !F_FULL;
        if (!F_FULL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign CMD_READY = (state_q == IDLE);
  assign BUSY      = !CMD_READY;
  assign GATE_EN   = gate_en;
  assign ALU_EN    = alu_en;
  assign ALU_FUN   = fun_q;
  assign W_INC     = w_inc;
  assign Wr_DATA   = wr_data;
  assign ERR       = err_q;

endmodule

// File: tb/tb_alu_op_sched.sv
// Directed bench for alu_op_sched; FIFO writes are checked against a queue of expected bytes.
module tb_alu_op_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic [3:0]  CMD_FUN = 4'h0;
  logic        CMD_ONE_BYTE = 1'b0;
  logic        CMD_READY;
  logic        GATE_EN;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT = 16'h0;
  logic        ALU_OUT_VALID = 1'b0;
  logic        F_FULL = 1'b0;
  logic        W_INC;
  logic [7:0]  Wr_DATA;
  logic        BUSY;
  logic        ERR;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  logic [7:0]  exp_q[$];
  logic        alu_respond = 1'b1;
  logic [15:0] alu_val = 16'h0;

  alu_op_sched #(.FUN_W(4), .OUT_W(16), .DATA_W(8), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_FUN(CMD_FUN),
    .CMD_ONE_BYTE(CMD_ONE_BYTE), .CMD_READY(CMD_READY), .GATE_EN(GATE_EN),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VALID(ALU_OUT_VALID), .F_FULL(F_FULL), .W_INC(W_INC),
    .Wr_DATA(Wr_DATA), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bench ALU: result valid for one cycle, the cycle after ALU_EN.
  initial begin
    forever begin
      @(negedge CLK);
      if (ALU_EN && alu_respond) begin
        @(posedge CLK);
        #1 ALU_OUT = alu_val;
        ALU_OUT_VALID = 1'b1;
        @(posedge CLK);
        #1 ALU_OUT_VALID = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (ERR) err_seen++;
      if (W_INC) begin
        chk("gate_off_during_write", {31'd0, GATE_EN}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'd0, Wr_DATA}, 32'hFFFF_FFFF);
        end else begin
          chk("wr_data", {24'd0, Wr_DATA}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge CLK);
    while (!CMD_READY && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (!CMD_READY) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Returns at #1 after the accepting edge k, i.e. inside cycle k+1.
  task automatic issue(input logic [3:0] f, input logic one);
    wait_ready();
    CMD_FUN = f;
    CMD_ONE_BYTE = one;
    CMD_VALID = 1'b1;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", {31'd0, CMD_READY}, 32'd1);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_gate", {31'd0, GATE_EN}, 32'd0);
    chk("rst_alu_en", {31'd0, ALU_EN}, 32'd0);
    chk("rst_fun", {28'd0, ALU_FUN}, 32'd0);
    chk("rst_winc", {31'd0, W_INC}, 32'd0);
    chk("rst_wdata", {24'd0, Wr_DATA}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b1;

    // Two-byte command, nominal latency
    alu_val = 16'hA55A;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    issue(4'h2, 1'b0);
    skip(1);
    chk("k1_gate", {31'd0, GATE_EN}, 32'd1);
    chk("k1_alu_en", {31'd0, ALU_EN}, 32'd0);
    chk("k1_busy", {31'd0, BUSY}, 32'd1);
    skip(1);
    chk("k2_alu_en", {31'd0, ALU_EN}, 32'd1);
    chk("k2_fun", {28'd0, ALU_FUN}, 32'h2);
    skip(1);
    chk("k3_alu_en", {31'd0, ALU_EN}, 32'd0);
    chk("k3_gate", {31'd0, GATE_EN}, 32'd1);
    skip(1);
    chk("k4_winc", {31'd0, W_INC}, 32'd1);
    skip(1);
    chk("k5_winc", {31'd0, W_INC}, 32'd1);
    chk("k5_ready", {31'd0, CMD_READY}, 32'd0);
    skip(1);
    chk("k6_ready", {31'd0, CMD_READY}, 32'd1);
    chk("k6_winc", {31'd0, W_INC}, 32'd0);
    chk("k6_fun_held", {28'd0, ALU_FUN}, 32'h2);

    // One-byte command
    exp_q.push_back(8'h5A);
    issue(4'h7, 1'b1);
    skip(2);
    chk("ob_fun", {28'd0, ALU_FUN}, 32'h7);
    skip(2);
    chk("ob_k4_winc", {31'd0, W_INC}, 32'd1);
    skip(1);
    chk("ob_k5_ready", {31'd0, CMD_READY}, 32'd1);
    chk("ob_k5_winc", {31'd0, W_INC}, 32'd0);

    // FIFO full stall of three cycles on entry to WR_LO
    alu_val = 16'h1234;
    F_FULL = 1'b1;
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    issue(4'h3, 1'b0);
    skip(4);
    for (int i = 0; i < 3; i++) begin
      chk("stall_winc", {31'd0, W_INC}, 32'd0);
      chk("stall_busy", {31'd0, BUSY}, 32'd1);
      if (i < 2) skip(1);
    end
    @(posedge CLK);
    #1 F_FULL = 1'b0;
    skip(1);
    chk("stall_lo_winc", {31'd0, W_INC}, 32'd1);
    chk("stall_lo_data", {24'd0, Wr_DATA}, 32'h34);
    wait_ready();
    chk("stall_queue_empty", exp_q.size(), 32'd0);

    // Timeout: ALU never answers
    alu_respond = 1'b0;
    issue(4'h5, 1'b0);
    begin
      logic early;
      early = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        skip(1);
        if (ERR) early = 1'b1;
      end
      chk("to_err_early", {31'd0, early}, 32'd0);
    end
    skip(1);
    chk("to_err", {31'd0, ERR}, 32'd1);
    chk("to_ready", {31'd0, CMD_READY}, 32'd1);
    skip(1);
    chk("to_err_single", {31'd0, ERR}, 32'd0);

    // Reset during WAIT
    issue(4'h6, 1'b0);
    skip(4);
    chk("rw_pre_gate", {31'd0, GATE_EN}, 32'd1);
    RST = 1'b0;
    #1;
    chk("rw_gate", {31'd0, GATE_EN}, 32'd0);
    chk("rw_ready", {31'd0, CMD_READY}, 32'd1);
    chk("rw_winc", {31'd0, W_INC}, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b1;

    // Reset during a WR_LO stall
    alu_respond = 1'b1;
    alu_val = 16'hDEAD;
    F_FULL = 1'b1;
    issue(4'h9, 1'b0);
    skip(5);
    chk("rs_stall_busy", {31'd0, BUSY}, 32'd1);
    RST = 1'b0;
    #1;
    chk("rs_busy", {31'd0, BUSY}, 32'd0);
    chk("rs_winc", {31'd0, W_INC}, 32'd0);
    chk("rs_err", {31'd0, ERR}, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b1;
    F_FULL = 1'b0;
    skip(3);

    // Normal command after the aborted ones
    alu_val = 16'hBEEF;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    issue(4'hC, 1'b0);
    skip(2);
    chk("post_fun", {28'd0, ALU_FUN}, 32'hC);
    wait_ready();
    skip(2);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    chk("err_pulse_count", err_seen, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sched.md
Name: alu_op_sched

Overview:
Sequences one ALU operation per accepted command on the REF_CLK domain. For each command it enables the ALU clock gate, pulses ALU_EN with the latched function code, and waits for the ALU result with a bounded timeout. It then splits the 16-bit result into bytes and writes them into the TX async FIFO under F_FULL back-pressure. It sits between the command decoder (requester) and the ALU, clock gate and TX FIFO write port.

Parameters:
FUN_W, 4, ALU function code width
OUT_W, 16, ALU result width; must be 2*DATA_W
DATA_W, 8, FIFO write data width
TIMEOUT, 8, max WAIT cycles for ALU_OUT_VALID; range 2..255

Ports:
CLK  in  1  REF_CLK domain clock
RST  in  1  asynchronous active-low reset
CMD_VALID  in  1  requester has a command
CMD_FUN  in  FUN_W  ALU function for the command
CMD_ONE_BYTE  in  1  1 = write low byte only; 0 = low then high byte
CMD_READY  out  1  scheduler can accept a command
GATE_EN  out  1  ALU clock gate enable
ALU_EN  out  1  one-cycle ALU start pulse
ALU_FUN  out  FUN_W  function code to ALU
ALU_OUT  in  OUT_W  ALU result
ALU_OUT_VALID  in  1  ALU result valid
F_FULL  in  1  TX FIFO full
W_INC  out  1  FIFO write strobe
Wr_DATA  out  DATA_W  FIFO write data
BUSY  out  1  operation in progress
ERR  out  1  one-cycle pulse on ALU timeout

Behaviour:
- States: IDLE, GATE_ON, EXEC, WAIT, WR_LO, WR_HI. State and all registers are cleared asynchronously when RST=0.
- Reset values: state=IDLE, GATE_EN=0, ALU_EN=0, ALU_FUN=0, W_INC=0, Wr_DATA=0, ERR=0, BUSY=0, CMD_READY=1, result register=0, timeout counter=0.
- A reset mid-operation abandons the operation. No further FIFO writes occur and no ERR is raised.
- CMD_READY = (state==IDLE). BUSY = !CMD_READY.
- IDLE: at an edge with CMD_VALID=1, latch CMD_FUN into ALU_FUN and CMD_ONE_BYTE into a mode bit, then go to GATE_ON. CMD_VALID=0 keeps the block in IDLE.
- GATE_ON: lasts one cycle (gate settle), then goes to EXEC.
- EXEC: lasts one cycle with ALU_EN=1, then goes to WAIT with the timeout counter at 0.
- GATE_EN=1 in GATE_ON, EXEC and WAIT only; 0 in all other states.
- ALU_EN is asserted only in EXEC. ALU_FUN holds the latched value from acceptance until the next acceptance.
- WAIT, ALU_OUT_VALID=1: capture ALU_OUT into the result register, then go to WR_LO.
- WAIT, ALU_OUT_VALID=0: increment the counter. If the counter == TIMEOUT-1, assert ERR for the next cycle (registered), go to IDLE, and make no FIFO writes.
- WAIT, valid and timeout in the same cycle: valid wins.
- ALU_OUT_VALID is ignored outside WAIT.
- WR_LO: W_INC = !F_FULL (combinational); Wr_DATA = result[DATA_W-1:0].
  - On an edge with F_FULL=0: go to IDLE if the mode bit is 1, otherwise go to WR_HI.
  - F_FULL=1: stay in WR_LO, with no limit on the stall length.
- WR_HI: same rules as WR_LO with Wr_DATA = result[OUT_W-1:DATA_W], then go to IDLE.
- Outside WR_LO/WR_HI: W_INC=0 and Wr_DATA holds its last value.
- Nominal latency with the command accepted at edge k:
  - GATE_EN rises in cycle k+1; ALU_EN high in cycle k+2.
  - With the ALU result valid in cycle k+3: low byte written in k+4, high byte written in k+5.
  - CMD_READY high again in cycle k+6 (k+5 for one-byte mode).
- Back-to-back commands: a new command is accepted at the first edge that has CMD_READY=1; there are no idle bubbles beyond that.

Test Plan:
- Reset → all outputs at reset values, CMD_READY=1. Release reset, then CMD_VALID=1, CMD_FUN=4'h2, CMD_ONE_BYTE=0 → GATE_EN rises next cycle, ALU_EN pulses exactly one cycle later with ALU_FUN=4'h2.
- Bench ALU returns 16'hA55A one cycle after ALU_EN, F_FULL=0 → W_INC pulses two consecutive cycles, Wr_DATA=8'h5A then 8'hA5. GATE_EN is 0 during the writes. CMD_READY returns 6 cycles after acceptance.
- Same as the previous case with CMD_ONE_BYTE=1 → exactly one write of 8'h5A, then IDLE.
- F_FULL=1 for 3 cycles on entry to WR_LO, then 0 → W_INC=0 during the stall, one write of the low byte, then the high byte. No byte is lost or duplicated.
- ALU_OUT_VALID never asserts, TIMEOUT=8 → ERR pulses once, 8 WAIT cycles after EXEC. No W_INC. CMD_READY=1 in the following cycle.
- Reset asserted during WAIT, and separately during a WR_LO stall → asynchronous return to IDLE. W_INC and GATE_EN drop immediately, no ERR, and the next command executes normally.
